// File: rtl/branch_predictor_pkg.sv
// Shared types and default sizing for the dynamic branch predictor.
// Provides the BTB geometry defaults and the saturating-counter opcode.
package branch_predictor_pkg;

   localparam int BP_XLEN      = 32;
   localparam int BP_BTB_DEPTH = 64;
   localparam int BP_TAG_W     = 10;
   localparam int BP_CNT_W     = 2;

   typedef enum logic [1:0] {
      CTR_HOLD = 2'd0,
      CTR_INC  = 2'd1,
      CTR_DEC  = 2'd2,
      CTR_MAX  = 2'd3
   } ctr_op_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update bundle between the pipeline and the predictor.
// The pipeline side is the master, the predictor is the slave.
interface branch_predictor_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pcF;
   logic            pred_takenF;
   logic [XLEN-1:0] pred_pcF;

   logic            upd_vldE;
   logic            upd_jmpE;
   logic [XLEN-1:0] upd_pcE;
   logic            upd_takenE;
   logic [XLEN-1:0] upd_targetE;
   logic            upd_pred_takenE;
   logic [XLEN-1:0] upd_pred_pcE;
   logic            mispredictE;
   logic [XLEN-1:0] redirect_pcE;

   logic [31:0]     br_cnt;
   logic [31:0]     miss_cnt;

   modport master (
      output pcF, upd_vldE, upd_jmpE, upd_pcE, upd_takenE, upd_targetE,
             upd_pred_takenE, upd_pred_pcE,
      input  pred_takenF, pred_pcF, mispredictE, redirect_pcE, br_cnt, miss_cnt
   );

   modport slave (
      input  pcF, upd_vldE, upd_jmpE, upd_pcE, upd_takenE, upd_targetE,
             upd_pred_takenE, upd_pred_pcE,
      output pred_takenF, pred_pcF, mispredictE, redirect_pcE, br_cnt, miss_cnt
   );

endinterface

// File: rtl/branch_predictor_sat_ctr.sv
// Saturating up/down counter step used on the BTB update path.
// Pure combinational: maps the current count and an opcode to the next count.
module bp_sat_ctr
   import branch_predictor_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  ctr_op_e          op,
   input  logic [CNT_W-1:0] cnt_i,
   output logic [CNT_W-1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      case (op)
         CTR_INC: if (cnt_i != '1) cnt_o = cnt_i + CNT_W'(1);
         CTR_DEC: if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
         CTR_MAX: cnt_o = '1;
         default: cnt_o = cnt_i;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: zero-latency lookup in F,
// training, mispredict detection and statistics from the resolved branch in E.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int XLEN      = BP_XLEN,
   parameter int BTB_DEPTH = BP_BTB_DEPTH,
   parameter int TAG_W     = BP_TAG_W,
   parameter int CNT_W     = BP_CNT_W,
   parameter bit PRED_EN   = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   branch_predictor_if.slave bp
);

   localparam int               IDX_W    = $clog2(BTB_DEPTH);
   localparam logic [CNT_W-1:0] CTR_WEAK = CNT_W'(1) << (CNT_W - 1);

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      if (&v) return v;
      return v + 32'd1;
   endfunction

   logic [BTB_DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
   logic [TAG_W-1:0]     tag_d    [BTB_DEPTH];
   logic [XLEN-1:0]      target_q [BTB_DEPTH];
   logic [XLEN-1:0]      target_d [BTB_DEPTH];
   logic [CNT_W-1:0]     ctr_q    [BTB_DEPTH];
   logic [CNT_W-1:0]     ctr_d    [BTB_DEPTH];
   logic [31:0]          br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0] idx_f, idx_e;
   logic [TAG_W-1:0] tag_f, tag_e;
   logic             hit_f, hit_e, pred_taken, commit_e, mispredict_e;
   ctr_op_e          ctr_op;
   logic [CNT_W-1:0] ctr_next;
   logic             unused_pc_bits;

   assign idx_f = bp.pcF[IDX_W+1:2];
   assign tag_f = bp.pcF[IDX_W+TAG_W+1:IDX_W+2];
   assign idx_e = bp.upd_pcE[IDX_W+1:2];
   assign tag_e = bp.upd_pcE[IDX_W+TAG_W+1:IDX_W+2];
   assign unused_pc_bits = ^{bp.pcF[1:0], bp.pcF[XLEN-1:IDX_W+TAG_W+2],
                             bp.upd_pcE[1:0], bp.upd_pcE[XLEN-1:IDX_W+TAG_W+2]};

   // Lookup reads only registered state, so a same-cycle update is not bypassed.
   assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_taken     = PRED_EN && rst_n && hit_f && ctr_q[idx_f][CNT_W-1];
   assign bp.pred_takenF = pred_taken;
   assign bp.pred_pcF    = pred_taken ? target_q[idx_f] : bp.pcF + XLEN'(4);

   assign hit_e          = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign commit_e       = bp.upd_vldE && rst_n;
   assign mispredict_e   = commit_e &&
                           ((bp.upd_pred_takenE != bp.upd_takenE) ||
                            (bp.upd_takenE && (bp.upd_pred_pcE != bp.upd_targetE)));
   assign bp.mispredictE  = mispredict_e;
   assign bp.redirect_pcE = bp.upd_takenE ? bp.upd_targetE : bp.upd_pcE + XLEN'(4);
   assign bp.br_cnt       = br_cnt_q;
   assign bp.miss_cnt     = miss_cnt_q;

   always_comb begin
      ctr_op = CTR_HOLD;
      if (hit_e) begin
         if (bp.upd_takenE) ctr_op = bp.upd_jmpE ? CTR_MAX : CTR_INC;
         else               ctr_op = CTR_DEC;
      end
   end

   bp_sat_ctr #(.CNT_W(CNT_W)) u_sat_ctr (
      .op    (ctr_op),
      .cnt_i (ctr_q[idx_e]),
      .cnt_o (ctr_next)
   );

   always_comb begin
      valid_d    = valid_q;
      tag_d      = tag_q;
      target_d   = target_q;
      ctr_d      = ctr_q;
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (commit_e) begin
         br_cnt_d = sat_inc32(br_cnt_q);
         if (mispredict_e) miss_cnt_d = sat_inc32(miss_cnt_q);
         if (hit_e) begin
            ctr_d[idx_e] = ctr_next;
            if (bp.upd_takenE) target_d[idx_e] = bp.upd_targetE;
         end else if (bp.upd_takenE) begin
            // Allocation also covers aliasing: a tag mismatch evicts the old entry.
            valid_d[idx_e]  = 1'b1;
            tag_d[idx_e]    = tag_e;
            target_d[idx_e] = bp.upd_targetE;
            ctr_d[idx_e]    = bp.upd_jmpE ? '1 : CTR_WEAK;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= '0;
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Payload arrays carry no reset; commit_e already blocks writes during reset.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
   end

endmodule
